// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: shared constants and types for the TDM 1-to-8 demux.
// FRAME_LEN grows to 9 when TDM_DEMUX_PARITY_EN is defined.
package tdm_demux_pkg;

   localparam int NCH    = 8;
   localparam int SEL_W  = 3;
   localparam int SLOT_W = 4;

`ifdef TDM_DEMUX_PARITY_EN
   localparam int FRAME_LEN = 9;
`else
   localparam int FRAME_LEN = 8;
`endif

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SYNC,
      RUN
   } state_t;

   // One-hot channel strobe for a written channel index.
   function automatic logic [NCH-1:0] ch_onehot(
      input logic [SEL_W-1:0] idx,
      input logic             hit
   );
      logic [NCH-1:0] v;
      v      = '0;
      v[idx] = hit;
      return v;
   endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: TDM slot position within the current frame.
// Loads 1 on a sync beat, wraps to 0 after FRAME_LEN-1.
module tdm_slot_ctr
   import tdm_demux_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              load1,
   input  logic              adv,
   output logic [SLOT_W-1:0] slot,
   output logic              last
);

   assign last = (slot == SLOT_W'(FRAME_LEN - 1));

   // Slot register: clear beats sync-load, sync-load beats advance.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         slot <= '0;
      end else if (load1) begin
         slot <= SLOT_W'(1);
      end else if (adv) begin
         slot <= last ? '0 : slot + SLOT_W'(1);
      end
   end

endmodule

// File: rtl/tdm_demux_1_to_8.sv
// tdm_demux_1_to_8: registered 1-to-8 demux, manual or TDM slot routing.
// Optional TDM_DEMUX_PARITY_EN adds a 9th even-parity beat per frame.
module tdm_demux_1_to_8
   import tdm_demux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 auto_mode,
   input  logic                 s0,
   input  logic                 s1,
   input  logic                 s2,
   input  logic [WIDTH-1:0]     din,
   input  logic                 din_valid,
   input  logic                 frame_sync,
   output logic [NCH*WIDTH-1:0] y,
   output logic [NCH-1:0]       y_stb,
   output logic                 frame_done,
   output logic                 frame_err,
   output logic                 parity_err
);

   state_t            state;
   logic [SLOT_W-1:0] slot;
   logic              last;

   logic              wr_en;
   logic [SEL_W-1:0]  wr_ch;
   logic [NCH-1:0]    stb;
   logic              ld_sync;
   logic              adv;
   logic              err_p;
   logic              done_p;
   logic              par_beat;
   logic              ctr_clr;

   assign ctr_clr = ~en | ~auto_mode;

   tdm_slot_ctr u_slot (
      .clk   (clk),
      .rst   (rst),
      .clr   (ctr_clr),
      .load1 (ld_sync),
      .adv   (adv),
      .slot  (slot),
      .last  (last)
   );

   // Beat decode: which channel (if any) this beat writes and which pulses fire.
   always_comb begin
      wr_en    = 1'b0;
      wr_ch    = '0;
      ld_sync  = 1'b0;
      adv      = 1'b0;
      err_p    = 1'b0;
      done_p   = 1'b0;
      par_beat = 1'b0;
      if (en) begin
         if (!auto_mode) begin
            wr_en = din_valid;
            wr_ch = {s2, s1, s0};
         end else if (din_valid) begin
            unique case (state)
               IDLE: begin
               end
               WAIT_SYNC: begin
                  if (frame_sync) begin
                     wr_en   = 1'b1;
                     ld_sync = 1'b1;
                  end
               end
               RUN: begin
                  if (frame_sync) begin
                     wr_en   = 1'b1;
                     ld_sync = 1'b1;
                     err_p   = (slot != '0);
                  end else begin
                     adv    = 1'b1;
                     done_p = last;
`ifdef TDM_DEMUX_PARITY_EN
                     par_beat = last;
`endif
                     wr_en  = ~par_beat;
                     wr_ch  = slot[SEL_W-1:0];
                  end
               end
               default: begin
               end
            endcase
         end
      end
      stb = ch_onehot(wr_ch, wr_en);
   end

   // FSM, channel registers and one-cycle strobes.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         y          <= '0;
         y_stb      <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         state      <= IDLE;
      end else begin
         y_stb      <= stb;
         frame_done <= done_p;
         frame_err  <= err_p;
         if (wr_en) begin
            y[int'(wr_ch)*WIDTH +: WIDTH] <= din;
         end
         if (!auto_mode) begin
            state <= WAIT_SYNC;
         end else begin
            unique case (state)
               IDLE:      state <= WAIT_SYNC;
               WAIT_SYNC: if (ld_sync) state <= RUN;
               RUN:       state <= RUN;
               default:   state <= IDLE;
            endcase
         end
      end
   end

`ifdef TDM_DEMUX_PARITY_EN
   logic acc;

   // Running XOR of the frame's data beats, checked against the parity beat.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         acc        <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         parity_err <= par_beat & (acc ^ din[0]);
         if (ld_sync) begin
            acc <= ^din;
         end else if (adv) begin
            acc <= par_beat ? 1'b0 : (acc ^ (^din));
         end
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_1_to_8.sv
// tb_tdm_demux_1_to_8: directed plus random checks against a frame-level model.
// Honours TDM_DEMUX_PARITY_EN for the frame length and parity beat.
module tb_tdm_demux_1_to_8;
   import tdm_demux_pkg::*;

   localparam int W = 1;
`ifdef TDM_DEMUX_PARITY_EN
   localparam int FLEN = 9;
   localparam bit PAR  = 1'b1;
`else
   localparam int FLEN = 8;
   localparam bit PAR  = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst, en, auto_mode, s0, s1, s2;
   logic [W-1:0]     din;
   logic             din_valid, frame_sync;
   logic [NCH*W-1:0] y;
   logic [NCH-1:0]   y_stb;
   logic             frame_done, frame_err, parity_err;

   int n_chk  = 0;
   int n_fail = 0;

   // Model: per-channel held data, frame phase and beat position.
   logic [W-1:0] m_ch [NCH];
   logic [NCH-1:0] m_stb;
   logic m_done, m_err, m_perr, m_acc;
   int   m_phase;
   int   m_pos;

   always #5 clk = ~clk;

   tdm_demux_1_to_8 #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .auto_mode  (auto_mode),
      .s0         (s0),
      .s1         (s1),
      .s2         (s2),
      .din        (din),
      .din_valid  (din_valid),
      .frame_sync (frame_sync),
      .y          (y),
      .y_stb      (y_stb),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   task automatic chk(input string tag, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [NCH*W-1:0] m_y();
      logic [NCH*W-1:0] v;
      for (int k = 0; k < NCH; k++) v[k*W +: W] = m_ch[k];
      return v;
   endfunction

   task automatic m_write(input int ch);
      m_ch[ch]  = din;
      m_stb     = '0;
      m_stb[ch] = 1'b1;
   endtask

   // phase: 0 idle, 1 hunting for sync, 2 inside frames
   task automatic model_step();
      m_stb  = '0;
      m_done = 1'b0;
      m_err  = 1'b0;
      m_perr = 1'b0;
      if (rst || !en) begin
         for (int k = 0; k < NCH; k++) m_ch[k] = '0;
         m_phase = 0;
         m_pos   = 0;
         m_acc   = 1'b0;
      end else if (!auto_mode) begin
         if (din_valid) m_write(int'({s2, s1, s0}));
         m_phase = 1;
         m_pos   = 0;
      end else if (m_phase == 0) begin
         m_phase = 1;
      end else if (din_valid) begin
         if (frame_sync) begin
            m_err   = (m_phase == 2) && (m_pos != 0);
            m_write(0);
            m_acc   = ^din;
            m_pos   = 1;
            m_phase = 2;
         end else if (m_phase == 2) begin
            if (PAR && m_pos == NCH) begin
               m_perr = m_acc ^ din[0];
            end else begin
               m_write(m_pos);
               m_acc = m_acc ^ (^din);
            end
            m_done = (m_pos == FLEN - 1);
            m_pos  = (m_pos + 1) % FLEN;
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      chk("y", y, m_y());
      chk("y_stb", y_stb, m_stb);
      chk("frame_done", frame_done, m_done);
      chk("frame_err", frame_err, m_err);
      chk("parity_err", parity_err, m_perr);
   endtask

   task automatic beat(input logic d, input logic sy);
      din_valid  = 1'b1;
      din        = W'(d);
      frame_sync = sy;
      cycle();
      din_valid  = 1'b0;
      frame_sync = 1'b0;
   endtask

   initial begin
      int done_cnt;
      logic [7:0] pat;
      rst = 1'b1; en = 1'b0; auto_mode = 1'b0;
      {s2, s1, s0} = 3'd0;
      din = '0; din_valid = 1'b0; frame_sync = 1'b0;
      m_phase = 0; m_pos = 0; m_acc = 1'b0;
      for (int k = 0; k < NCH; k++) m_ch[k] = '0;

      cycle();
      cycle();
      chk("rst_y", y, '0);
      chk("rst_stb", y_stb, '0);

      // Manual route to channel 5
      rst = 1'b0; en = 1'b1;
      cycle();
      {s2, s1, s0} = 3'd5;
      beat(1'b1, 1'b0);
      chk("t1_y", y, 8'h20);
      chk("t1_stb", y_stb, 8'h20);
      cycle();

      // Full auto frame
      auto_mode = 1'b1;
      cycle();
      cycle();
      pat = 8'b0100_1101;
      done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         beat(pat[i], i == 0);
         done_cnt += int'(frame_done);
      end
      chk("t2_y", y, 8'b0100_1101);
      chk("t2_done_cnt", done_cnt, 1);
      if (PAR) beat(^pat, 1'b0);

      // Resync mid-frame
      beat(1'b0, 1'b1);
      beat(1'b1, 1'b0);
      beat(1'b1, 1'b0);
      beat(1'b1, 1'b0);
      chk("t3_no_err", frame_err, 1'b0);
      beat(1'b1, 1'b1);
      chk("t3_err", frame_err, 1'b1);
      chk("t3_stb", y_stb, 8'h01);
      beat(1'b0, 1'b0);
      chk("t3_slot1", y_stb, 8'h02);

      // en drop at slot 4
      beat(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) beat(1'b1, 1'b0);
      en = 1'b0;
      cycle();
      chk("t4_y", y, '0);
      en = 1'b1;
      for (int i = 0; i < 4; i++) beat(1'b1, 1'b0);
      chk("t4_drop", y, '0);

      // rst mid-run
      beat(1'b1, 1'b1);
      beat(1'b1, 1'b0);
      rst = 1'b1;
      cycle();
      chk("t5_y", y, '0);
      rst = 1'b0;
      cycle();
      cycle();
      if (PAR) begin
         beat(1'b1, 1'b1);
         for (int i = 1; i < 8; i++) beat(1'b0, 1'b0);
         beat(1'b0, 1'b0);
         chk("t5_perr", parity_err, 1'b1);
      end

      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 299) == 0);
         en  = ($urandom_range(0, 59) != 0);
         if (auto_mode) begin
            if ($urandom_range(0, 149) == 0) auto_mode = 1'b0;
         end else begin
            if ($urandom_range(0, 19) == 0) auto_mode = 1'b1;
         end
         din_valid = ($urandom_range(0, 9) < 7);
         din = W'($urandom);
         {s2, s1, s0} = 3'($urandom);
         if (m_pos == 0)
            frame_sync = ($urandom_range(0, 3) != 0);
         else
            frame_sync = ($urandom_range(0, 29) == 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
